// File: rtl/odd_even_sorter_pkg.sv
// Shared types and default sizing for the sorter that feeds the median stage.
//   DATA_WIDTH / DATA_SIZE : default sample width and window length
//   PHASE_W                : width of the phase counter for the default window
//   data_t                 : one unsigned sample
//   sorter_state_e         : sorter FSM encoding
package median_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int DATA_SIZE  = 9;
    localparam int PHASE_W    = $clog2(DATA_SIZE + 1);

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } sorter_state_e;
endpackage

// File: rtl/odd_even_sorter_if.sv
// Handshake/data bundle between the sample source and the sorter.
//   start_i   : capture numbers_i and sort (only acted on while idle)
//   numbers_i : unsorted window, index 0 first
//   busy_o    : sort in progress
//   ready_o   : one-cycle pulse, numbers_o just updated
//   numbers_o : sorted window, index 0 = minimum
// master = sample source, slave = sorter.
interface odd_even_sorter_if #(
    parameter int DATA_WIDTH = median_pkg::DATA_WIDTH,
    parameter int DATA_SIZE  = median_pkg::DATA_SIZE
);
    logic                                 start_i;
    logic [DATA_SIZE-1:0][DATA_WIDTH-1:0] numbers_i;
    logic                                 busy_o;
    logic                                 ready_o;
    logic [DATA_SIZE-1:0][DATA_WIDTH-1:0] numbers_o;

    modport master (output start_i, numbers_i, input busy_o, ready_o, numbers_o);
    modport slave  (input start_i, numbers_i, output busy_o, ready_o, numbers_o);
endinterface

// File: rtl/odd_even_sorter_compare_exchange.sv
// Combinational compare-exchange cell for unsigned operands.
//   a, b    : operands (a is the lower index)
//   lo, hi  : min / max of the pair
//   swapped : high when a > b; equal values stay in place
module compare_exchange #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swapped
);
    assign swapped = (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;
endmodule

// File: rtl/odd_even_sorter.sv
// Sequential odd-even transposition sorter.
// Captures DATA_SIZE samples on start, runs one compare-exchange phase per
// clock (even pairs on even phases, odd pairs on odd phases), then publishes
// the ascending result on numbers_o with a one-cycle ready_o pulse.
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset
//   bus    : odd_even_sorter_if slave (start_i, numbers_i, busy_o, ready_o, numbers_o)
// Optional build macro SORTER_EARLY_EXIT_EN: leave SORT once an even and an
// odd phase in a row made no swap (array already ordered).
module odd_even_sorter #(
    parameter int DATA_WIDTH = median_pkg::DATA_WIDTH,
    parameter int DATA_SIZE  = median_pkg::DATA_SIZE
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    odd_even_sorter_if.slave  bus
);
    import median_pkg::*;

    localparam int PW   = $clog2(DATA_SIZE + 1);
    localparam int NE   = DATA_SIZE / 2;        // pairs (0,1),(2,3),...
    localparam int NO   = (DATA_SIZE - 1) / 2;  // pairs (1,2),(3,4),...
    localparam int NO_A = (NO > 0) ? NO : 1;

    typedef logic [DATA_SIZE-1:0][DATA_WIDTH-1:0] arr_t;

    sorter_state_e state;
    logic [PW-1:0] phase;
    arr_t          work;
    arr_t          numbers_q;
    logic          ready_q;
    arr_t          even_next;
    arr_t          odd_next;
    arr_t          phase_next;

    logic [NE-1:0][DATA_WIDTH-1:0]   e_lo, e_hi;
    logic [NE-1:0]                   e_sw;
    logic [NO_A-1:0][DATA_WIDTH-1:0] o_lo, o_hi;
    logic [NO_A-1:0]                 o_sw;

    for (genvar i = 0; i < NE; i++) begin : g_even
        compare_exchange #(.W(DATA_WIDTH)) u_ce (
            .a(work[2*i]), .b(work[2*i+1]),
            .lo(e_lo[i]), .hi(e_hi[i]), .swapped(e_sw[i])
        );
    end

    if (NO > 0) begin : g_odd
        for (genvar i = 0; i < NO; i++) begin : g_pair
            compare_exchange #(.W(DATA_WIDTH)) u_ce (
                .a(work[2*i+1]), .b(work[2*i+2]),
                .lo(o_lo[i]), .hi(o_hi[i]), .swapped(o_sw[i])
            );
        end
    end else begin : g_no_odd
        assign o_lo = '0;
        assign o_hi = '0;
        assign o_sw = '0;
    end

    // Unpaired edge elements keep their value from the default copy.
    always_comb begin
        even_next = work;
        odd_next  = work;
        for (int i = 0; i < NE; i++) begin
            even_next[2*i]   = e_lo[i];
            even_next[2*i+1] = e_hi[i];
        end
        for (int i = 0; i < NO; i++) begin
            odd_next[2*i+1] = o_lo[i];
            odd_next[2*i+2] = o_hi[i];
        end
        phase_next = phase[0] ? odd_next : even_next;
    end

`ifdef SORTER_EARLY_EXIT_EN
    logic any_swap;
    logic prev_clean;   // previous phase made no swap
    assign any_swap = phase[0] ? |o_sw : |e_sw;
`else
    logic unused_sw;
    assign unused_sw = ^{e_sw, o_sw};
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            phase     <= '0;
            work      <= '0;
            numbers_q <= '0;
            ready_q   <= 1'b0;
`ifdef SORTER_EARLY_EXIT_EN
            prev_clean <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        work  <= bus.numbers_i;
                        phase <= '0;
                        state <= SORT;
`ifdef SORTER_EARLY_EXIT_EN
                        prev_clean <= 1'b0;
`endif
                    end
                end
                SORT: begin
                    work  <= phase_next;
                    phase <= phase + 1'b1;
                    if (phase == PW'(DATA_SIZE - 1))
                        state <= DONE;
`ifdef SORTER_EARLY_EXIT_EN
                    prev_clean <= !any_swap;
                    if (prev_clean && !any_swap)
                        state <= DONE;
`endif
                end
                DONE: begin
                    numbers_q <= work;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o    = (state != IDLE);
    assign bus.ready_o   = ready_q;
    assign bus.numbers_o = numbers_q;
endmodule

// File: tb/tb_odd_even_sorter.sv
module tb_odd_even_sorter;
    typedef logic [8:0][7:0] word_t;
    typedef struct packed {
        word_t in;
        word_t exp;
        logic [7:0] lat;   // expected edges start->ready, 0 = not checked
    } vec_t;

    logic clk;
    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;

    odd_even_sorter_if bus ();
    odd_even_sorter u_dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));

    always #5 clk = ~clk;

    function automatic word_t w9(int a0, int a1, int a2, int a3, int a4,
                                 int a5, int a6, int a7, int a8);
        word_t r;
        r[0] = a0[7:0]; r[1] = a1[7:0]; r[2] = a2[7:0];
        r[3] = a3[7:0]; r[4] = a4[7:0]; r[5] = a5[7:0];
        r[6] = a6[7:0]; r[7] = a7[7:0]; r[8] = a8[7:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue start at a negedge; return edges to ready and busy-high samples.
    task automatic run_sort(input word_t in, output int lat, output int bc);
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.numbers_i = in;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bc  = bus.busy_o ? 1 : 0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.ready_o) break;
            if (bus.busy_o) bc++;
        end
        chk("ready_seen", {71'd0, bus.ready_o}, 72'd1);
    endtask

    vec_t tbl[6];

    initial begin
        int lat, bc, g, rdy_cnt;
        word_t sa, sb;

`ifdef SORTER_EARLY_EXIT_EN
        tbl[0] = '{w9(9,8,7,6,5,4,3,2,1),          w9(1,2,3,4,5,6,7,8,9),          8'd10};
        tbl[1] = '{w9(255,0,7,7,255,0,128,7,1),    w9(0,0,1,7,7,7,128,255,255),    8'd0};
        tbl[2] = '{w9(1,2,3,4,5,6,7,8,9),          w9(1,2,3,4,5,6,7,8,9),          8'd3};
        tbl[3] = '{w9(5,5,5,5,5,5,5,5,5),          w9(5,5,5,5,5,5,5,5,5),          8'd3};
        tbl[4] = '{w9(3,1,4,1,5,9,2,6,5),          w9(1,1,2,3,4,5,5,6,9),          8'd0};
        tbl[5] = '{w9(0,255,0,255,0,255,0,255,0),  w9(0,0,0,0,0,255,255,255,255),  8'd0};
`else
        tbl[0] = '{w9(9,8,7,6,5,4,3,2,1),          w9(1,2,3,4,5,6,7,8,9),          8'd10};
        tbl[1] = '{w9(255,0,7,7,255,0,128,7,1),    w9(0,0,1,7,7,7,128,255,255),    8'd10};
        tbl[2] = '{w9(1,2,3,4,5,6,7,8,9),          w9(1,2,3,4,5,6,7,8,9),          8'd10};
        tbl[3] = '{w9(5,5,5,5,5,5,5,5,5),          w9(5,5,5,5,5,5,5,5,5),          8'd10};
        tbl[4] = '{w9(3,1,4,1,5,9,2,6,5),          w9(1,1,2,3,4,5,5,6,9),          8'd10};
        tbl[5] = '{w9(0,255,0,255,0,255,0,255,0),  w9(0,0,0,0,0,255,255,255,255),  8'd10};
`endif

        clk = 1'b0;
        rstn = 1'b0;
        bus.start_i = 1'b0;
        bus.numbers_i = '0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_numbers", bus.numbers_o, 72'd0);
        chk("rst_ready_busy", {70'd0, bus.ready_o, bus.busy_o}, 72'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("idle_quiet", {bus.ready_o, bus.busy_o, bus.numbers_o[6:0]}, 72'd0);
        end

        // Table-driven sorts
        for (int k = 0; k < 6; k++) begin
            run_sort(tbl[k].in, lat, bc);
            chk($sformatf("sorted_%0d", k), bus.numbers_o, tbl[k].exp);
            chk($sformatf("median_%0d", k), {64'd0, bus.numbers_o[4]}, {64'd0, tbl[k].exp[4]});
            if (tbl[k].lat != 8'd0) begin
                chk($sformatf("latency_%0d", k), 72'(lat), 72'(tbl[k].lat));
                chk($sformatf("busy_cycles_%0d", k), 72'(bc), 72'(tbl[k].lat));
            end
            @(posedge clk);
            #1;
            chk($sformatf("pulse_width_%0d", k), {71'd0, bus.ready_o}, 72'd0);
            chk($sformatf("held_%0d", k), bus.numbers_o, tbl[k].exp);
        end

        // start held high across a sort with changing numbers_i
        sa = w9(0,0,1,7,7,7,128,255,255);
        sb = w9(10,20,30,40,50,60,70,80,90);
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.numbers_i = w9(255,0,7,7,255,0,128,7,1);
        @(posedge clk);
        @(negedge clk);
        bus.numbers_i = w9(90,80,70,60,50,40,30,20,10);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) break;
        end
        chk("held_first_ready", {71'd0, bus.ready_o}, 72'd1);
        chk("held_first_set", bus.numbers_o, sa);
        g = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            g++;
            if (bus.ready_o) break;
        end
        chk("held_gap", 72'(g), 72'd11);
        chk("held_second_set", bus.numbers_o, sb);
        @(negedge clk);
        bus.start_i = 1'b0;

        // Reset at phase 4 aborts the sort
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.numbers_i = w9(9,8,7,6,5,4,3,2,1);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_before", {71'd0, bus.busy_o}, 72'd1);
        rstn = 1'b0;
        #1;
        chk("abort_numbers", bus.numbers_o, 72'd0);
        chk("abort_ready_busy", {70'd0, bus.ready_o, bus.busy_o}, 72'd0);
        @(negedge clk);
        rstn = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o || bus.busy_o) rdy_cnt++;
        end
        chk("abort_no_ready", 72'(rdy_cnt), 72'd0);
        run_sort(w9(3,1,4,1,5,9,2,6,5), lat, bc);
        chk("after_abort_sorted", bus.numbers_o, w9(1,1,2,3,4,5,5,6,9));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
